lzc_norm_sched: RTL and testbench
=================================

Name: lzc_norm_sched

Overview:
- Shared normalization resource for the FPU: one 128-bit leading-one detector (lzc_128) plus a left normalization shifter, time-shared among NUM_REQ requesters (FMA, add/sub, div/sqrt, int-to-float convert).
- Round-robin arbitration, valid/ready handshakes on both sides, 2-stage stallable pipeline.
- Returns leading-zero count, zero flag and normalized mantissa, tagged with source ID and requester tag.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥ 2 and a power of 2.
- TAG_W, 4, width of the opaque requester tag carried through the pipeline.
- SRC_W, $clog2(NUM_REQ), width of the source index; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous; discards all in-flight entries.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*128  operand; requester i uses bits [i*128 +: 128].
- req_tag  in  NUM_REQ*TAG_W  tag; requester i uses bits [i*TAG_W +: TAG_W].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_src  out  SRC_W  index of the requester that issued the result.
- rsp_tag  out  TAG_W  tag of that request.
- rsp_lzc  out  7  leading-zero count, 0..127.
- rsp_zero  out  1  operand was all zeros.
- rsp_norm  out  128  operand << rsp_lzc.

Behaviour:
- Reset: rsp_valid=0, S1/S2 valid=0, RR pointer=0, req_ready=0. rsp_src, rsp_tag, rsp_lzc, rsp_zero and rsp_norm reset to 0.
- Pipeline control:
  - s2_adv = !S2.valid | rsp_ready.
  - s1_load = !S1.valid | s2_adv.
  - rsp_valid = S2.valid.
- Arbitration:
  - Combinational round-robin search over req_valid, starting at ptr and wrapping at NUM_REQ-1 -> 0.
  - grant is one-hot; req_ready = grant & {NUM_REQ{s1_load & !flush}}.
  - req_ready does not depend on any req_valid other than through the grant.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. On transfer, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
- S1 (capture):
  - On transfer: S1 <= {1, i, tag, data}.
  - Else if s1_load: S1.valid <= 0.
- S1 compute:
  - lzc_128 on S1.data gives MSB index p (7 bits) and nz (any bit set).
  - If nz: lzc = 127 - p. Else: lzc = 0.
  - norm = nz ? data << lzc : 0.
- S2:
  - If s2_adv: S2 <= {S1.valid, src, tag, lzc, !nz, norm}.
  - If !s2_adv: S2 holds all fields stable, and S1 holds.
- Latency and throughput: latency 2 cycles (accept at edge T, rsp_valid from T+2). Throughput 1 result/cycle while rsp_ready=1.
- Stall:
  - With rsp_ready=0 and both stages full, req_ready=0. No request is lost or duplicated.
  - rsp_* outputs are stable while rsp_valid & !rsp_ready.
- Flush:
  - Next cycle: S1.valid=0, S2.valid=0, req_ready=0 during the flush cycle.
  - ptr is unchanged.
  - A response presented during the flush cycle with rsp_ready=1 still counts as consumed.
- Reset has priority over flush. Reset mid-operation drops all entries.
- Simultaneous load and drain: S1 forwards to S2 and accepts a new request in the same cycle when rsp_ready=1.
- Requesters must hold req_valid, req_data and req_tag until accepted. Behaviour on dropping valid before acceptance is undefined.

Test Plan:
- Single request: req 0, data=128'h1, tag=3 -> rsp_valid 2 cycles later; rsp_src=0, tag=3, lzc=127, zero=0, norm=1<<127.
- Boundary values:
  - data=1<<127 -> lzc=0, norm=data.
  - data=128'h100 -> lzc=119, norm=1<<127.
  - data=0 -> lzc=0, zero=1, norm=0.
- Fairness: all 4 req_valid held high for 8 accepts -> grant order 0,1,2,3,0,1,2,3. With only reqs 1 and 3 valid and ptr=2 -> order 3,1,3,1.
- Back-pressure: continuous requests with rsp_ready=0 for 5 cycles -> exactly 2 accepts, then req_ready=0. rsp_* stable throughout. After rsp_ready=1, results arrive in accept order, none dropped or duplicated.
- Flush with S1 and S2 full -> rsp_valid=0 next cycle, no stale responses, ptr unchanged; the next request completes normally with latency 2.
- Reset asserted mid-stream for 1 cycle -> all outputs 0 next cycle, ptr=0; first post-reset grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/lzc_norm_sched.sv
// Shared leading-zero count and normalization unit, time-shared among NUM_REQ
// FPU requesters through a round-robin arbiter feeding a 2-stage stallable pipeline.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop every in-flight entry (takes effect at the next edge)
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_data/req_tag      per-requester 128-bit operand and opaque tag (packed by index)
//   rsp_valid/rsp_ready   result handshake
//   rsp_src, rsp_tag      issuing requester index and its tag
//   rsp_lzc, rsp_zero     leading-zero count (0 for a zero operand) and zero flag
//   rsp_norm              operand shifted left by rsp_lzc
module lzc_norm_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 4,
    localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*128-1:0]   req_data,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [SRC_W-1:0]         rsp_src,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [6:0]               rsp_lzc,
    output logic                     rsp_zero,
    output logic [127:0]             rsp_norm
);

    // Pipeline state
    logic [SRC_W-1:0] ptr_q;
    logic             s1_valid_q;
    logic [SRC_W-1:0] s1_src_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [127:0]     s1_data_q;
    logic             s2_valid_q;
    logic [SRC_W-1:0] s2_src_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [6:0]       s2_lzc_q;
    logic             s2_zero_q;
    logic [127:0]     s2_norm_q;

    logic             s2_adv;
    logic             s1_load;
    logic             found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] idx;
    logic [NUM_REQ-1:0] grant;
    logic             xfer;
    logic [SRC_W-1:0] ptr_d;

    logic [6:0]       msb_idx;
    logic             nz;
    logic [6:0]       lzc;
    logic [127:0]     norm;

    assign s2_adv  = !s2_valid_q || rsp_ready;
    assign s1_load = !s1_valid_q || s2_adv;

    // Round-robin search starting at ptr_q; NUM_REQ is a power of two so the
    // SRC_W-bit add wraps naturally.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + SRC_W'(k);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    // rst also gates acceptance so nothing is handed off into a stage being cleared.
    assign req_ready = grant & {NUM_REQ{s1_load && !flush && !rst}};
    assign xfer      = |(req_valid & req_ready);
    assign ptr_d     = xfer ? grant_idx + SRC_W'(1) : ptr_q;

    // Leading-one detector: the highest set bit wins.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < 128; i++) begin
            if (s1_data_q[i]) begin
                msb_idx = 7'(i);
            end
        end
    end

    assign nz   = |s1_data_q;
    assign lzc  = nz ? 7'd127 - msb_idx : 7'd0;
    assign norm = nz ? s1_data_q << lzc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_tag_q   <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_src_q   <= '0;
            s2_tag_q   <= '0;
            s2_lzc_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_norm_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (xfer) begin
                s1_valid_q <= 1'b1;
                s1_src_q   <= grant_idx;
                s1_tag_q   <= req_tag[int'(grant_idx)*TAG_W +: TAG_W];
                s1_data_q  <= req_data[int'(grant_idx)*128 +: 128];
            end else if (s1_load) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                s2_src_q   <= s1_src_q;
                s2_tag_q   <= s1_tag_q;
                s2_lzc_q   <= lzc;
                s2_zero_q  <= !nz;
                s2_norm_q  <= norm;
            end
            // Flush only clears valids; the payload left behind is never presented.
            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_src   = s2_src_q;
    assign rsp_tag   = s2_tag_q;
    assign rsp_lzc   = s2_lzc_q;
    assign rsp_zero  = s2_zero_q;
    assign rsp_norm  = s2_norm_q;

endmodule

// File: tb/tb_lzc_norm_sched.sv
// Directed self-checking bench for lzc_norm_sched (NUM_REQ=4, TAG_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_lzc_norm_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [511:0] req_data;
    logic [15:0]  req_tag;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_src;
    logic [3:0]   rsp_tag;
    logic [6:0]   rsp_lzc;
    logic         rsp_zero;
    logic [127:0] rsp_norm;

    int total = 0;
    int bad   = 0;

    logic [127:0] bd_data [5];
    logic [6:0]   bd_lzc  [5];
    logic         bd_zero [5];
    logic [127:0] bd_norm [5];

    always #5 clk = ~clk;

    lzc_norm_sched #(
        .NUM_REQ (4),
        .TAG_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_src   (rsp_src),
        .rsp_tag   (rsp_tag),
        .rsp_lzc   (rsp_lzc),
        .rsp_zero  (rsp_zero),
        .rsp_norm  (rsp_norm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [127:0] d, input logic [3:0] t);
        req_data[i*128 +: 128] = d;
        req_tag[i*4 +: 4]      = t;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        req_data = '0; req_tag = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid);
        end
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        total++;
        if ({rsp_src, rsp_tag, rsp_lzc, rsp_zero} !== 14'd0) begin
            bad++; $display("FAIL reset_fields: got src=%0d tag=%0d lzc=%0d zero=%b want all 0",
                            rsp_src, rsp_tag, rsp_lzc, rsp_zero);
        end
        total++;
        if (rsp_norm !== 128'd0) begin
            bad++; $display("FAIL reset_norm: got %h want 0", rsp_norm);
        end
    endtask

    task automatic test_fairness_all();
        for (int i = 0; i < 4; i++) set_req(i, 128'h1 << (i*8 + 1), 4'(i + 1));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                bad++; $display("FAIL fair_all_grant k=%0d: got %b want %b",
                                k, req_ready, 4'(1 << (k % 4)));
            end
            if (k >= 2) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_src !== 2'((k - 2) % 4)) begin
                    bad++; $display("FAIL fair_all_rsp k=%0d: got valid=%b src=%0d want 1/%0d",
                                    k, rsp_valid, rsp_src, (k - 2) % 4);
                end
            end
            step();
        end
        req_valid = '0;
        step(); step(); step();
    endtask

    task automatic test_fairness_pair();
        int exp_src;
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL pair_setup: got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_src = (k % 2 == 0) ? 3 : 1;
            #1;
            total++;
            if (req_ready !== 4'(1 << exp_src)) begin
                bad++; $display("FAIL pair_grant k=%0d: got %b want %b",
                                k, req_ready, 4'(1 << exp_src));
            end
            step();
        end
        req_valid = '0;
        step(); step(); step();
    endtask

    task automatic test_single();
        logic [127:0] exp_norm;
        exp_norm = 128'h1 << 127;
        set_req(0, 128'h1, 4'd3);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_early: got valid=%b want 0", rsp_valid);
        end
        step();
        #1;
        total++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_lzc, rsp_zero} !== {1'b1, 2'd0, 4'd3, 7'd127, 1'b0})
        begin
            bad++; $display("FAIL single_rsp: got v=%b src=%0d tag=%0d lzc=%0d zero=%b want 1/0/3/127/0",
                            rsp_valid, rsp_src, rsp_tag, rsp_lzc, rsp_zero);
        end
        total++;
        if (rsp_norm !== exp_norm) begin
            bad++; $display("FAIL single_norm: got %h want %h", rsp_norm, exp_norm);
        end
        step(); step();
    endtask

    task automatic test_boundary();
        int src;
        bd_data[0] = 128'h1 << 127; bd_lzc[0] = 7'd0;   bd_zero[0] = 1'b0; bd_norm[0] = 128'h1 << 127;
        bd_data[1] = 128'h100;      bd_lzc[1] = 7'd119; bd_zero[1] = 1'b0; bd_norm[1] = 128'h1 << 127;
        bd_data[2] = 128'h0;        bd_lzc[2] = 7'd0;   bd_zero[2] = 1'b1; bd_norm[2] = 128'h0;
        bd_data[3] = 128'hF00;      bd_lzc[3] = 7'd116; bd_zero[3] = 1'b0; bd_norm[3] = 128'hF << 124;
        bd_data[4] = '1;            bd_lzc[4] = 7'd0;   bd_zero[4] = 1'b0; bd_norm[4] = '1;
        for (int e = 0; e < 5; e++) begin
            src = e % 4;
            set_req(src, bd_data[e], 4'(e + 4));
            req_valid = 4'(1 << src);
            step();
            req_valid = '0;
            step();
            #1;
            total++;
            if ({rsp_valid, rsp_src, rsp_tag} !== {1'b1, 2'(src), 4'(e + 4)}) begin
                bad++; $display("FAIL bound_id e=%0d: got v=%b src=%0d tag=%0d want 1/%0d/%0d",
                                e, rsp_valid, rsp_src, rsp_tag, src, e + 4);
            end
            total++;
            if (rsp_lzc !== bd_lzc[e] || rsp_zero !== bd_zero[e]) begin
                bad++; $display("FAIL bound_lzc e=%0d: got lzc=%0d zero=%b want %0d/%b",
                                e, rsp_lzc, rsp_zero, bd_lzc[e], bd_zero[e]);
            end
            total++;
            if (rsp_norm !== bd_norm[e]) begin
                bad++; $display("FAIL bound_norm e=%0d: got %h want %h", e, rsp_norm, bd_norm[e]);
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        int  acc;
        logic took;
        logic [127:0] exp_norm;
        exp_norm = 128'h1 << 127;
        acc = 0;
        rsp_ready = 1'b0;
        set_req(2, 128'h400, 4'd5);
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c >= 2) begin
                total++;
                if ({rsp_valid, rsp_src, rsp_tag, rsp_lzc} !== {1'b1, 2'd2, 4'd5, 7'd117}) begin
                    bad++; $display("FAIL bp_hold c=%0d: got v=%b src=%0d tag=%0d lzc=%0d want 1/2/5/117",
                                    c, rsp_valid, rsp_src, rsp_tag, rsp_lzc);
                end
                total++;
                if (rsp_norm !== exp_norm) begin
                    bad++; $display("FAIL bp_hold_norm c=%0d: got %h want %h", c, rsp_norm, exp_norm);
                end
            end
            took = req_ready[2];
            step();
            if (took) begin
                acc++;
                if (acc == 1) set_req(2, 128'h1 << 100, 4'd6);
                else          set_req(2, 128'h8, 4'd7);
            end
        end
        total++;
        if (acc != 2) begin
            bad++; $display("FAIL bp_accepts: got %0d want 2", acc);
        end
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL bp_ready: got %b want 0000", req_ready);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        total++;
        if ({rsp_valid, rsp_tag, rsp_lzc} !== {1'b1, 4'd5, 7'd117}) begin
            bad++; $display("FAIL bp_drain0: got v=%b tag=%0d lzc=%0d want 1/5/117",
                            rsp_valid, rsp_tag, rsp_lzc);
        end
        step();
        #1;
        total++;
        if ({rsp_valid, rsp_tag, rsp_lzc} !== {1'b1, 4'd6, 7'd27}) begin
            bad++; $display("FAIL bp_drain1: got v=%b tag=%0d lzc=%0d want 1/6/27",
                            rsp_valid, rsp_tag, rsp_lzc);
        end
        step();
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain_end: got v=%b want 0", rsp_valid);
        end
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) set_req(i, 128'h1 << (20 + i), 4'(8 + i));
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL flush_fill0: got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL flush_fill1: got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        flush = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
            bad++; $display("FAIL flush_cycle: got ready=%b v=%b want 0000/1", req_ready, rsp_valid);
        end
        step();
        flush = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            bad++; $display("FAIL flush_after: got v=%b ready=%b want 0/1000", rsp_valid, req_ready);
        end
        step();
        req_valid = 4'b0011;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            bad++; $display("FAIL flush_t1: got v=%b ready=%b want 0/0001", rsp_valid, req_ready);
        end
        step();
        req_valid = 4'b0010;
        #1;
        total++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_lzc} !== {1'b1, 2'd3, 4'd11, 7'd104} ||
            req_ready !== 4'b0010) begin
            bad++; $display("FAIL flush_first: got v=%b src=%0d tag=%0d lzc=%0d ready=%b want 1/3/11/104/0010",
                            rsp_valid, rsp_src, rsp_tag, rsp_lzc, req_ready);
        end
        step();
        req_valid = '0;
        #1;
        total++;
        if ({rsp_valid, rsp_src, rsp_tag} !== {1'b1, 2'd0, 4'd8}) begin
            bad++; $display("FAIL flush_second: got v=%b src=%0d tag=%0d want 1/0/8",
                            rsp_valid, rsp_src, rsp_tag);
        end
        step();
        #1;
        total++;
        if ({rsp_valid, rsp_src, rsp_tag} !== {1'b1, 2'd1, 4'd9}) begin
            bad++; $display("FAIL flush_third: got v=%b src=%0d tag=%0d want 1/1/9",
                            rsp_valid, rsp_src, rsp_tag);
        end
        step();
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_end: got v=%b want 0", rsp_valid);
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) set_req(i, 128'h1 << (40 + i), 4'(12 + i));
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (req_ready !== 4'(1 << ((2 + k) % 4))) begin
                bad++; $display("FAIL rmid_grant k=%0d: got %b want %b",
                                k, req_ready, 4'(1 << ((2 + k) % 4)));
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_lzc, rsp_zero} !== 15'd0 || rsp_norm !== 128'd0) begin
            bad++; $display("FAIL rmid_outputs: got v=%b src=%0d tag=%0d lzc=%0d zero=%b norm=%h want 0",
                            rsp_valid, rsp_src, rsp_tag, rsp_lzc, rsp_zero, rsp_norm);
        end
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_early: got v=%b want 0", rsp_valid);
        end
        step();
        #1;
        total++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_lzc} !== {1'b1, 2'd0, 4'd12, 7'd87}) begin
            bad++; $display("FAIL rmid_rsp: got v=%b src=%0d tag=%0d lzc=%0d want 1/0/12/87",
                            rsp_valid, rsp_src, rsp_tag, rsp_lzc);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fairness_all();
        test_fairness_pair();
        test_single();
        test_boundary();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
